anpc_multileg_seq: RTL and testbench

Parametrised multi-leg switching sequencer for 3L-ANPC converters. It turns a per-leg voltage-level command (P / 0 / N) and a thermal zero-state selector into safe six-switch gate patterns. Each leg gets an overlap-free dead phase and a minimum-hold phase. It adds direct P↔N routing through a zero state, a latched global fault shutdown and per-leg busy flags. It sits between the modulator / thermal decision logic and the gate-driver outputs, and replaces the single-leg FSM.

---
 rtl/anpc_multileg_seq_pkg.sv | 54 +++++
 rtl/anpc_multileg_seq_leg.sv | 156 +++++++++++++++
 rtl/anpc_multileg_seq.sv | 59 +++++
 tb/tb_anpc_multileg_seq.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/anpc_multileg_seq_pkg.sv
// Shared types, gate patterns and selection helpers for the 3L-ANPC sequencer.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
// Pattern bit order is {S1,S2,S3,S4,S5,S6}, MSB = S1.
package PKG_anpc_seq;

  typedef enum logic [2:0] {P, Z_U2, Z_U1, Z_L1, Z_L2, N} states_t;

  typedef enum logic [1:0] {IDLE, DEAD, HOLD} phase_t;

  localparam logic [5:0] PAT_P    = 6'b110_001;
  localparam logic [5:0] PAT_Z_U2 = 6'b010_010;
  localparam logic [5:0] PAT_Z_U1 = 6'b011_010;
  localparam logic [5:0] PAT_Z_L1 = 6'b011_001;
  localparam logic [5:0] PAT_Z_L2 = 6'b001_001;
  localparam logic [5:0] PAT_N    = 6'b001_110;
  localparam logic [5:0] PAT_OFF  = 6'b000_000;

  // Gate pattern for a switching state. Unused encodings map to all-off.
  function automatic logic [5:0] pattern_of(states_t s);
    logic [5:0] pat;
    case (s)
      P:       pat = PAT_P;
      Z_U2:    pat = PAT_Z_U2;
      Z_U1:    pat = PAT_Z_U1;
      Z_L1:    pat = PAT_Z_L1;
      Z_L2:    pat = PAT_Z_L2;
      N:       pat = PAT_N;
      default: pat = PAT_OFF;
    endcase
    return pat;
  endfunction

  // Zero state entered when leaving P or N. The thermal selector is
  // interpreted relative to the rail being left.
  function automatic states_t zero_select(states_t from, logic [1:0] z);
    states_t zs;
    if (from == N) begin
      case (z)
        2'd2:    zs = Z_U2;
        2'd3:    zs = Z_U1;
        default: zs = Z_L2;
      endcase
    end else begin
      case (z)
        2'd2:    zs = Z_L2;
        2'd3:    zs = Z_L1;
        default: zs = Z_U2;
      endcase
    end
    return zs;
  endfunction

endpackage

// File: rtl/anpc_multileg_seq_leg.sv
// One converter leg: state/phase FSM, dead and hold counter, registered gates.
// Latency: command sampled in IDLE shows its DEAD pattern on the next cycle.
// Backpressure: none; commands are ignored while DEAD/HOLD or fault latched.
// Ports: clk_i/rst_i; t_dead_i/t_min_i timing; v_lev_i/z_type_i command;
//        fault_i raw request, fault_lat_i latched fault, fault_clr_i clear;
//        s_o six gate signals, busy_o high in DEAD/HOLD.
module anpc_leg
  import PKG_anpc_seq::*;
#(
  parameter int TDELAY_WIDTH = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [TDELAY_WIDTH-1:0] t_dead_i,
  input  logic [TDELAY_WIDTH-1:0] t_min_i,
  input  logic [1:0]              v_lev_i,
  input  logic [1:0]              z_type_i,
  input  logic                    fault_i,
  input  logic                    fault_lat_i,
  input  logic                    fault_clr_i,
  output logic [5:0]              s_o,
  output logic                    busy_o
);

  localparam logic [TDELAY_WIDTH-1:0] CNT_ONE = TDELAY_WIDTH'(1);

  phase_t                  phase_q, phase_d;
  states_t                 cur_q, cur_d;
  states_t                 tgt_q, tgt_d;
  logic [TDELAY_WIDTH-1:0] cnt_q, cnt_d;
  logic [5:0]              s_q, s_d;
  logic                    busy_q, busy_d;

  logic [TDELAY_WIDTH-1:0] dead_len, hold_len;
  logic                    go;
  states_t                 nxt;
  logic                    gates_off;

  // A zero timing input still gives one cycle of separation.
  assign dead_len = (t_dead_i == '0) ? CNT_ONE : t_dead_i;
  assign hold_len = (t_min_i == '0) ? CNT_ONE : t_min_i;

  // Target selection from the settled state. P<->N is routed through the
  // selected zero state; the second half is picked up by a later IDLE
  // evaluation if the command is still present.
  always_comb begin
    go  = 1'b0;
    nxt = cur_q;
    case (cur_q)
      P: begin
        if (v_lev_i == 2'b00 || v_lev_i == 2'b10) begin
          nxt = zero_select(P, z_type_i);
          go  = 1'b1;
        end
      end
      N: begin
        if (v_lev_i == 2'b00 || v_lev_i == 2'b01) begin
          nxt = zero_select(N, z_type_i);
          go  = 1'b1;
        end
      end
      default: begin
        if (v_lev_i == 2'b01) begin
          nxt = P;
          go  = 1'b1;
        end else if (v_lev_i == 2'b10) begin
          nxt = N;
          go  = 1'b1;
        end
      end
    endcase
  end

  always_comb begin
    phase_d   = phase_q;
    cur_d     = cur_q;
    tgt_d     = tgt_q;
    cnt_d     = cnt_q;
    gates_off = fault_i | (fault_lat_i & ~fault_clr_i);

    if (fault_i || fault_lat_i) begin
      // Abort (or clear back to) the safe zero state; the gates stay off
      // until the clear is accepted.
      phase_d = IDLE;
      cur_d   = Z_U2;
      tgt_d   = Z_U2;
      cnt_d   = '0;
    end else begin
      case (phase_q)
        IDLE: begin
          if (go) begin
            tgt_d   = nxt;
            phase_d = DEAD;
            cnt_d   = dead_len;
          end
        end
        DEAD: begin
          if (cnt_q <= CNT_ONE) begin
            phase_d = HOLD;
            cnt_d   = hold_len;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        HOLD: begin
          if (cnt_q <= CNT_ONE) begin
            phase_d = IDLE;
            cur_d   = tgt_q;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        default: begin
          phase_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    // Outputs are derived from the next state so they are registered
    // alongside it and never glitch at the driver pins.
    if (gates_off) begin
      s_d = PAT_OFF;
    end else if (phase_d == DEAD) begin
      s_d = pattern_of(cur_d) & pattern_of(tgt_d);
    end else if (phase_d == HOLD) begin
      s_d = pattern_of(tgt_d);
    end else begin
      s_d = pattern_of(cur_d);
    end
    busy_d = ~gates_off & (phase_d != IDLE);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      phase_q <= IDLE;
      cur_q   <= Z_U2;
      tgt_q   <= Z_U2;
      cnt_q   <= '0;
      s_q     <= PAT_Z_U2;
      busy_q  <= 1'b0;
    end else begin
      phase_q <= phase_d;
      cur_q   <= cur_d;
      tgt_q   <= tgt_d;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
      busy_q  <= busy_d;
    end
  end

  assign s_o    = s_q;
  assign busy_o = busy_q;

endmodule

// File: rtl/anpc_multileg_seq.sv
// Multi-leg 3L-ANPC switching sequencer: N_LEGS independent legs plus a fault latch.
// Latency: one cycle from a sampled command/fault to registered gate outputs.
// Backpressure: none; legs ignore commands while busy, fault overrides all.
// Ports: clk, reset (async, active high); t_dead/t_min shared timing;
//        v_lev/z_type per-leg 2-bit slices; fault/fault_clr;
//        S_out per-leg 6-bit slices {S1..S6}, busy per leg, fault_active.
module anpc_multileg_seq
  import PKG_anpc_seq::*;
#(
  parameter int N_LEGS       = 3,
  parameter int TDELAY_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [TDELAY_WIDTH-1:0] t_dead,
  input  logic [TDELAY_WIDTH-1:0] t_min,
  input  logic [2*N_LEGS-1:0]     v_lev,
  input  logic [2*N_LEGS-1:0]     z_type,
  input  logic                    fault,
  input  logic                    fault_clr,
  output logic [6*N_LEGS-1:0]     S_out,
  output logic [N_LEGS-1:0]       busy,
  output logic                    fault_active
);

  logic fault_q;

  // Set dominates clear so a fault coinciding with a clear stays latched.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fault_q <= 1'b0;
    end else if (fault) begin
      fault_q <= 1'b1;
    end else if (fault_clr) begin
      fault_q <= 1'b0;
    end
  end

  assign fault_active = fault_q;

  for (genvar i = 0; i < N_LEGS; i++) begin : g_leg
    anpc_leg #(
      .TDELAY_WIDTH(TDELAY_WIDTH)
    ) u_leg (
      .clk_i       (clk),
      .rst_i       (reset),
      .t_dead_i    (t_dead),
      .t_min_i     (t_min),
      .v_lev_i     (v_lev[2*i +: 2]),
      .z_type_i    (z_type[2*i +: 2]),
      .fault_i     (fault),
      .fault_lat_i (fault_q),
      .fault_clr_i (fault_clr),
      .s_o         (S_out[6*i +: 6]),
      .busy_o      (busy[i])
    );
  end

endmodule

// File: tb/tb_anpc_multileg_seq.sv
// Scoreboard bench for anpc_multileg_seq (3 legs): directed command vectors
// push per-cycle expected gate/busy/fault values; a monitor compares them.
module tb_anpc_multileg_seq;

  localparam logic [5:0] P_  = 6'b110_001;
  localparam logic [5:0] ZU2 = 6'b010_010;
  localparam logic [5:0] ZU1 = 6'b011_010;
  localparam logic [5:0] N_  = 6'b001_110;
  localparam logic [5:0] OFF = 6'b000_000;

  logic        clk;
  logic        reset;
  logic [15:0] t_dead;
  logic [15:0] t_min;
  logic [5:0]  v_lev;
  logic [5:0]  z_type;
  logic        fault;
  logic        fault_clr;
  logic [17:0] S_out;
  logic [2:0]  busy;
  logic        fault_active;

  anpc_multileg_seq #(
    .N_LEGS(3),
    .TDELAY_WIDTH(16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .t_dead       (t_dead),
    .t_min        (t_min),
    .v_lev        (v_lev),
    .z_type       (z_type),
    .fault        (fault),
    .fault_clr    (fault_clr),
    .S_out        (S_out),
    .busy         (busy),
    .fault_active (fault_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [31:0] cyc;
    logic [17:0] s;
    logic [2:0]  b;
    logic        fa;
  } exp_t;

  exp_t  sb[$];
  string nq[$];
  int    tests = 0;
  int    errors = 0;
  int    k;

  task automatic cmp(input string nm, input logic [17:0] s_e, input logic [2:0] b_e, input logic fa_e);
    tests++;
    if (S_out !== s_e || busy !== b_e || fault_active !== fa_e) begin
      errors++;
      $display("FAIL %s @cyc %0d: got S_out=%b busy=%b fault_active=%b, expected S_out=%b busy=%b fault_active=%b",
               nm, cyc, S_out, busy, fault_active, s_e, b_e, fa_e);
    end
  endtask

  task automatic exp(input int c, input logic [5:0] a0, input logic [5:0] a1, input logic [5:0] a2,
                     input logic [2:0] b, input logic fa, input string nm);
    exp_t e;
    e.cyc = c;
    e.s   = {a2, a1, a0};
    e.b   = b;
    e.fa  = fa;
    sb.push_back(e);
    nq.push_back(nm);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic set_v(input int leg, input logic [1:0] v);
    v_lev[2*leg +: 2] = v;
  endtask

  // Monitor: every cycle, check the no-shoot-through invariant and retire
  // any expectation due for this cycle.
  initial begin
    exp_t  e;
    string nm;
    forever begin
      @(negedge clk);
      #1;
      if (!reset) begin
        for (int l = 0; l < 3; l++) begin
          logic [5:0] s;
          s = S_out[6*l +: 6];
          tests++;
          if ((s[5] & s[3]) | (s[4] & s[2])) begin
            errors++;
            $display("FAIL overlap leg%0d @cyc %0d: got %b, required no S1&S3 / S2&S4", l, cyc, s);
          end
        end
      end
      while (sb.size() > 0 && int'(sb[0].cyc) <= cyc) begin
        e  = sb.pop_front();
        nm = nq.pop_front();
        if (int'(e.cyc) < cyc) begin
          tests++;
          errors++;
          $display("FAIL %s: checked late at cyc %0d, required cyc %0d", nm, cyc, e.cyc);
        end else begin
          cmp(nm, e.s, e.b, e.fa);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit, %0d expectations pending", sb.size());
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    t_dead    = 16'd1;
    t_min     = 16'd1;
    v_lev     = 6'b111111;
    z_type    = 6'b000000;
    fault     = 1'b0;
    fault_clr = 1'b0;
    repeat (3) step();
    reset = 1'b0;
    exp(cyc + 1, ZU2, ZU2, ZU2, 3'b000, 1'b0, "reset_state");
    step(); step();

    // T1: Z_U2 -> P, t_dead 3, t_min 5; v_lev toggles in HOLD are ignored.
    k = cyc;
    t_dead = 16'd3; t_min = 16'd5; set_v(0, 2'b01);
    for (int j = 1; j <= 3; j++) exp(k + j, 6'b010_000, ZU2, ZU2, 3'b001, 1'b0, "t1_dead");
    for (int j = 4; j <= 8; j++) exp(k + j, P_, ZU2, ZU2, 3'b001, 1'b0, "t1_hold");
    exp(k + 9,  P_, ZU2, ZU2, 3'b000, 1'b0, "t1_idle");
    exp(k + 10, P_, ZU2, ZU2, 3'b000, 1'b0, "t1_toggle_ignored");
    step(); set_v(0, 2'b11);
    step(); step(); step();
    for (int j = 0; j < 5; j++) begin
      set_v(0, j[0] ? 2'b00 : 2'b10);
      step();
    end
    set_v(0, 2'b11);
    step(); step();

    // T2: P -> N via zero state Z_U2 (z_type 1), t_dead = t_min = 1.
    k = cyc;
    t_dead = 16'd1; t_min = 16'd1; z_type[1:0] = 2'b01; set_v(0, 2'b10);
    exp(k + 1, 6'b010_000, ZU2, ZU2, 3'b001, 1'b0, "t2_dead_pz");
    exp(k + 2, ZU2, ZU2, ZU2, 3'b001, 1'b0, "t2_hold_z");
    exp(k + 3, ZU2, ZU2, ZU2, 3'b000, 1'b0, "t2_idle_z");
    exp(k + 4, 6'b000_010, ZU2, ZU2, 3'b001, 1'b0, "t2_dead_zn");
    exp(k + 5, N_, ZU2, ZU2, 3'b001, 1'b0, "t2_hold_n");
    exp(k + 6, N_, ZU2, ZU2, 3'b000, 1'b0, "t2_idle_n");
    repeat (6) step();
    set_v(0, 2'b11);
    step();

    // T3: zero timing behaves as 1/1; N -> Z_U1 (z_type 3), 00 holds in Z.
    k = cyc;
    t_dead = 16'd0; t_min = 16'd0; z_type[1:0] = 2'b11; set_v(0, 2'b00);
    exp(k + 1, 6'b001_010, ZU2, ZU2, 3'b001, 1'b0, "t3_dead");
    exp(k + 2, ZU1, ZU2, ZU2, 3'b001, 1'b0, "t3_hold");
    exp(k + 3, ZU1, ZU2, ZU2, 3'b000, 1'b0, "t3_idle");
    exp(k + 4, ZU1, ZU2, ZU2, 3'b000, 1'b0, "t3_zero_holds");
    repeat (4) step();
    set_v(0, 2'b11); z_type = 6'b000000;
    step();

    // T4: independent legs, leg2 started one cycle later; t_dead changed
    // mid-DEAD must not affect running counters.
    k = cyc;
    t_dead = 16'd2; t_min = 16'd1; set_v(0, 2'b01); set_v(1, 2'b10);
    exp(k + 1, 6'b010_000, 6'b000_010, ZU2,        3'b011, 1'b0, "t4_c1");
    exp(k + 2, 6'b010_000, 6'b000_010, 6'b010_000, 3'b111, 1'b0, "t4_c2");
    exp(k + 3, P_,         N_,         6'b010_000, 3'b111, 1'b0, "t4_c3");
    exp(k + 4, P_,         N_,         P_,         3'b100, 1'b0, "t4_c4");
    exp(k + 5, P_,         N_,         P_,         3'b000, 1'b0, "t4_c5");
    step(); set_v(0, 2'b11); set_v(1, 2'b11); set_v(2, 2'b01);
    step(); set_v(2, 2'b11); t_dead = 16'd7;
    repeat (4) step();

    // T5: fault during leg1 DEAD, clear, then fault+clear together.
    k = cyc;
    t_dead = 16'd4; t_min = 16'd1; z_type[3:2] = 2'b10; set_v(1, 2'b00);
    exp(k + 1, P_,  6'b000_010, P_, 3'b010, 1'b0, "t5_leg1_dead");
    exp(k + 2, OFF, OFF, OFF, 3'b000, 1'b1, "t5_fault");
    exp(k + 3, OFF, OFF, OFF, 3'b000, 1'b1, "t5_fault_latched");
    exp(k + 4, ZU2, ZU2, ZU2, 3'b000, 1'b0, "t5_cleared");
    exp(k + 5, ZU2, ZU2, ZU2, 3'b000, 1'b0, "t5_idle_after_clr");
    exp(k + 6, OFF, OFF, OFF, 3'b000, 1'b1, "t5_fault_beats_clr");
    exp(k + 7, OFF, OFF, OFF, 3'b000, 1'b1, "t5_still_latched");
    exp(k + 8, ZU2, ZU2, ZU2, 3'b000, 1'b0, "t5_cleared2");
    step(); set_v(1, 2'b11); fault = 1'b1;
    step(); fault = 1'b0;
    step(); fault_clr = 1'b1; set_v(0, 2'b01);
    step(); fault_clr = 1'b0; set_v(0, 2'b11);
    step(); fault = 1'b1; fault_clr = 1'b1;
    step(); fault = 1'b0; fault_clr = 1'b0;
    step(); fault_clr = 1'b1;
    step(); fault_clr = 1'b0; z_type = 6'b000000;
    step();

    // T6: asynchronous reset in the middle of HOLD.
    k = cyc;
    t_dead = 16'd1; t_min = 16'd6; set_v(0, 2'b01);
    exp(k + 1, 6'b010_000, ZU2, ZU2, 3'b001, 1'b0, "t6_dead");
    exp(k + 2, P_, ZU2, ZU2, 3'b001, 1'b0, "t6_hold");
    exp(k + 3, P_, ZU2, ZU2, 3'b001, 1'b0, "t6_hold2");
    step(); set_v(0, 2'b11);
    step(); step();
    #3;
    reset = 1'b1;
    #1;
    cmp("t6_async_reset", {ZU2, ZU2, ZU2}, 3'b000, 1'b0);
    step(); step();
    reset = 1'b0;
    k = cyc;
    exp(k + 1, ZU2, ZU2, ZU2, 3'b000, 1'b0, "t6_after_reset");
    exp(k + 3, ZU2, ZU2, ZU2, 3'b000, 1'b0, "t6_discarded");
    repeat (4) step();

    if (sb.size() != 0) begin
      tests++;
      errors++;
      $display("FAIL scoreboard_drain: %0d expectations left, required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
